decoder_scan: RTL
=================

// Module: decoder_scan
// PURPOSE
//  Parametrised, registered N-to-2^N line decoder with three-input enable gating (E1_n, E2_n, E3 style).
//  Two modes: DIRECT decodes addr each cycle; SCAN auto-steps the active line with a programmable dwell time.
//  Used as the digit/row strobe generator ahead of LED/keypad matrix drivers.
// PARAMETERS
//  SEL_W    3  select width; output count = 2**SEL_W (SEL_W >= 1)
//  DWELL    4  cycles each line stays active in SCAN (DWELL >= 1)
//  ACT_LOW  1  1: active line driven 0, inactive lines 1; 0: inverted
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           asynchronous reset, active-high
//  e1_n     in   1           enable, active-low
//  e2_n     in   1           enable, active-low
//  e3       in   1           enable, active-high
//  mode     in   1           0 = DIRECT, 1 = SCAN
//  addr     in   SEL_W       DIRECT select; SCAN load value
//  load     in   1           SCAN only: jump to addr
//  y_n      out  2**SEL_W    decoded lines, polarity per ACT_LOW, registered
//  cur_sel  out  SEL_W       index of the currently selected line, registered
//  wrap     out  1           1-cycle pulse when SCAN steps from the last line to line 0
// BEHAVIOUR
//  - en = ~e1_n & ~e2_n & e3. All outputs are registers; every input takes effect 1 cycle after the sampling edge.
//  - Reset (async assert, sync release):
//    y_n = all inactive ('1s if ACT_LOW, else '0); cur_sel = 0; dwell_cnt = 0; wrap = 0; state = OFF.
//  - States: OFF, DIRECT, SCAN (plus BLANK under DEC_BLANK_EN). State is chosen every cycle from en and mode:
//    !en -> OFF; en & !mode -> DIRECT; en & mode -> SCAN.
//  - OFF: y_n all inactive; cur_sel and dwell_cnt hold; wrap = 0. Re-enabling resumes at the held position.
//  - DIRECT: cur_sel <= addr; y_n <= onehot(addr); dwell_cnt <= 0; wrap = 0. load is ignored.
//  - SCAN: y_n = onehot(cur_sel). dwell_cnt counts 0..DWELL-1.
//    At DWELL-1: cur_sel <= cur_sel + 1 modulo 2**SEL_W, and dwell_cnt <= 0.
//    The advance from 2**SEL_W-1 to 0 asserts wrap for exactly the cycle in which cur_sel first reads 0.
//  - DWELL = 1: cur_sel advances every cycle. dwell_cnt width = max(1, $clog2(DWELL)).
//  - load in SCAN: cur_sel <= addr, dwell_cnt <= 0, no wrap. load has priority over a simultaneous advance.
//  - DIRECT -> SCAN: scanning starts from the current cur_sel (the last addr) with dwell_cnt = 0.
//    SCAN -> DIRECT: addr takes over on the next cycle.
//  - Exactly one line is active whenever the block is enabled and not blanking. No line is active while OFF or in BLANK.
//  - Reset mid-scan forces reset values immediately; scanning restarts from line 0.
// CONFIGURATION
//  DEC_BLANK_EN defined: each SCAN advance inserts one BLANK cycle (all lines inactive) before the next line goes active.
//    The per-line period becomes DWELL+1. cur_sel updates when BLANK is entered.
//    wrap pulses on the BLANK cycle that precedes line 0.
//    load during BLANK: cur_sel <= addr, and the addr line goes active on the next cycle.
//    Disable during BLANK goes to OFF.
//  DEC_BLANK_EN undefined: no BLANK state; lines switch back-to-back with no gap.
// TESTING
//  1. rst=1 async mid-cycle -> y_n=8'hFF, cur_sel=0, wrap=0 immediately (defaults).
//  2. DIRECT, en, addr=5 -> next cycle y_n=8'b1101_1111, cur_sel=5. Set e3=0 -> next cycle y_n=8'hFF, cur_sel holds 5.
//  3. SCAN, DWELL=4, start from sel 0 -> each line active exactly 4 cycles, order 0,1..7,0.
//     wrap=1 for the single cycle cur_sel returns to 0 (every 32 cycles).
//  4. SCAN at sel=3 with dwell_cnt=3, load=1, addr=6 on the same edge -> cur_sel=6 (not 4) and line 6 held for 4 cycles.
//  5. SCAN disabled at sel=2, dwell_cnt=1 for 5 cycles -> y_n=8'hFF.
//     Re-enable -> line 2 active for the remaining 2 cycles, then line 3.
//  6. DEC_BLANK_EN, DWELL=2 -> pattern: line0, line0, blank, line1, line1, blank...
//     wrap on the blank before line 0. Repeat case 3 with ACT_LOW=0 -> y_n polarity inverted.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N line decoder with 3-input enable gating and an auto-scan mode.
// Latency: every input affects the outputs one clock after the edge that samples it.
// Backpressure: none; free-running strobe generator, outputs update every cycle.
//
// Optional feature macro: DEC_BLANK_EN
//   defined   - each scan advance inserts one all-inactive BLANK cycle before the next line.
//   undefined - lines switch back-to-back with no gap.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous reset, active-high
//   i_e1_n     enable, active-low
//   i_e2_n     enable, active-low
//   i_e3       enable, active-high
//   i_mode     0 = DIRECT (decode i_addr), 1 = SCAN (auto-step)
//   i_addr     DIRECT select / SCAN load value
//   i_load     SCAN only: jump to i_addr
//   o_y_n      decoded lines, active level set by ACT_LOW, registered
//   o_cur_sel  index of the currently selected line, registered
//   o_wrap     one-cycle pulse when the scan steps from the last line to line 0
module decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL   = 4,
    parameter int ACT_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_e1_n,
    input  logic                  i_e2_n,
    input  logic                  i_e3,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_addr,
    input  logic                  i_load,
    output logic [2**SEL_W-1:0]   o_y_n,
    output logic [SEL_W-1:0]      o_cur_sel,
    output logic                  o_wrap
);

    localparam int N  = 2**SEL_W;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    // All lines at their inactive level.
    localparam logic [N-1:0] Y_IDLE = {N{ACT_LOW != 0}};

    // ST_BLANK is only reachable when DEC_BLANK_EN is defined.
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLANK  = 2'd3
    } state_t;

    state_t            r_state;
    logic [N-1:0]      r_y_n;
    logic [SEL_W-1:0]  r_cur_sel;
    logic [DW-1:0]     r_dwell;
    logic              r_wrap;

    logic              w_en;
    logic              w_last;
    logic              w_sel_max;
    logic [SEL_W-1:0]  w_sel_inc;
    logic [N-1:0]      w_line_cur;
    logic [N-1:0]      w_line_inc;
    logic [N-1:0]      w_line_addr;

    // One-hot line pattern for a select value, with the configured polarity.
    function automatic logic [N-1:0] f_line(input logic [SEL_W-1:0] sel);
        logic [N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return (ACT_LOW != 0) ? ~v : v;
    endfunction

    assign w_en        = ~i_e1_n & ~i_e2_n & i_e3;
    assign w_last      = (r_dwell == DWELL_LAST);
    assign w_sel_max   = &r_cur_sel;
    assign w_sel_inc   = r_cur_sel + SEL_W'(1);   // natural wrap modulo 2**SEL_W
    assign w_line_cur  = f_line(r_cur_sel);
    assign w_line_inc  = f_line(w_sel_inc);
    assign w_line_addr = f_line(i_addr);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_OFF;
            r_y_n     <= Y_IDLE;
            r_cur_sel <= '0;
            r_dwell   <= '0;
            r_wrap    <= 1'b0;
        end else if (!w_en) begin
            // Position and dwell hold so re-enabling resumes mid-line.
            r_state <= ST_OFF;
            r_y_n   <= Y_IDLE;
            r_wrap  <= 1'b0;
        end else if (!i_mode) begin
            r_state   <= ST_DIRECT;
            r_y_n     <= w_line_addr;
            r_cur_sel <= i_addr;
            r_dwell   <= '0;
            r_wrap    <= 1'b0;
        end else if (i_load) begin
            // Load wins over a coincident advance and never reports a wrap.
            r_state   <= ST_SCAN;
            r_y_n     <= w_line_addr;
            r_cur_sel <= i_addr;
            r_dwell   <= '0;
            r_wrap    <= 1'b0;
        end else if (r_state == ST_BLANK) begin
            // cur_sel already moved on entry to BLANK; just light it up.
            r_state <= ST_SCAN;
            r_y_n   <= w_line_cur;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
        end else if (w_last) begin
`ifdef DEC_BLANK_EN
            r_state <= ST_BLANK;
            r_y_n   <= Y_IDLE;
`else
            r_state <= ST_SCAN;
            r_y_n   <= w_line_inc;
`endif
            r_cur_sel <= w_sel_inc;
            r_dwell   <= '0;
            r_wrap    <= w_sel_max;
        end else begin
            // Also the resume path from OFF/DIRECT: dwell keeps counting from where it held.
            r_state <= ST_SCAN;
            r_y_n   <= w_line_cur;
            r_dwell <= r_dwell + DW'(1);
            r_wrap  <= 1'b0;
        end
    end

`ifdef DEC_BLANK_EN
    logic [N-1:0] w_unused_inc;
    assign w_unused_inc = w_line_inc;
`endif

    assign o_y_n     = r_y_n;
    assign o_cur_sel = r_cur_sel;
    assign o_wrap    = r_wrap;

endmodule
